// File: rtl/mfp_ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter in front of the matrix master port.
// Losers are stalled via their HREADY and replayed from a one-entry pending slot.
module mfp_ahb_lite_arbiter_2m #(
    parameter int ROUND_ROBIN = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic [31:0] m0_HADDR,
    input  logic [ 2:0] m0_HBURST,
    input  logic        m0_HMASTLOCK,
    input  logic [ 3:0] m0_HPROT,
    input  logic [ 2:0] m0_HSIZE,
    input  logic [ 1:0] m0_HTRANS,
    input  logic        m0_HWRITE,
    input  logic [31:0] m0_HWDATA,
    output logic [31:0] m0_HRDATA,
    output logic        m0_HREADY,
    output logic        m0_HRESP,

    input  logic [31:0] m1_HADDR,
    input  logic [ 2:0] m1_HBURST,
    input  logic        m1_HMASTLOCK,
    input  logic [ 3:0] m1_HPROT,
    input  logic [ 2:0] m1_HSIZE,
    input  logic [ 1:0] m1_HTRANS,
    input  logic        m1_HWRITE,
    input  logic [31:0] m1_HWDATA,
    output logic [31:0] m1_HRDATA,
    output logic        m1_HREADY,
    output logic        m1_HRESP,

    output logic [31:0] s_HADDR,
    output logic [ 2:0] s_HBURST,
    output logic        s_HMASTLOCK,
    output logic [ 3:0] s_HPROT,
    output logic [ 2:0] s_HSIZE,
    output logic [ 1:0] s_HTRANS,
    output logic        s_HWRITE,
    output logic [31:0] s_HWDATA,
    input  logic [31:0] s_HRDATA,
    input  logic        s_HREADY,
    input  logic        s_HRESP
);

    typedef struct packed {
        logic [31:0] addr;
        logic [ 2:0] size;
        logic [ 3:0] prot;
        logic        write;
        logic        lock;
    } req_t;

    req_t       live    [2];
    req_t       src     [2];
    req_t       pend_q  [2];
    req_t       sel;
    logic [1:0] trans   [2];

    logic [1:0] pend_vld_q, pend_vld_d;
    logic       dph_vld_q,  dph_vld_d;
    logic       dph_idx_q,  dph_idx_d;
    logic       lock_vld_q, lock_vld_d;
    logic       lock_idx_q, lock_idx_d;
    logic       last_q,     last_d;

    logic [1:0] mready;
    logic [1:0] accept;
    logic [1:0] cand;
    logic       issue;
    logic       gnt;
    logic       contended;

    // Bursts are always split into singles, so the incoming burst type is not needed.
    logic unused_burst;
    assign unused_burst = ^{m0_HBURST, m1_HBURST};

    assign live[0] = '{addr: m0_HADDR, size: m0_HSIZE, prot: m0_HPROT,
                       write: m0_HWRITE, lock: m0_HMASTLOCK};
    assign live[1] = '{addr: m1_HADDR, size: m1_HSIZE, prot: m1_HPROT,
                       write: m1_HWRITE, lock: m1_HMASTLOCK};
    assign trans[0] = m0_HTRANS;
    assign trans[1] = m1_HTRANS;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (pend_vld_q[i])
                mready[i] = 1'b0;
            else if (dph_vld_q && (dph_idx_q == i[0]))
                mready[i] = s_HREADY;
            else
                mready[i] = 1'b1;
            accept[i] = trans[i][1] & mready[i];
            cand[i]   = pend_vld_q[i] | accept[i];
            src[i]    = pend_vld_q[i] ? pend_q[i] : live[i];
        end
    end

    // Arbitration: lock owner first, then fixed priority or round-robin.
    always_comb begin
        issue = 1'b0;
        gnt   = 1'b0;
        if (s_HREADY && (cand != 2'b00)) begin
            if (lock_vld_q) begin
                issue = cand[lock_idx_q];
                gnt   = lock_idx_q;
            end else if (cand == 2'b11) begin
                issue = 1'b1;
                gnt   = (ROUND_ROBIN != 0) ? ~last_q : 1'b1;
            end else begin
                issue = 1'b1;
                gnt   = cand[1];
            end
        end
        contended = issue & (cand == 2'b11) & ~lock_vld_q;
        sel       = src[gnt];
    end

    always_comb begin
        pend_vld_d = pend_vld_q;
        dph_vld_d  = dph_vld_q;
        dph_idx_d  = dph_idx_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        last_d     = last_q;
        for (int i = 0; i < 2; i++) begin
            if (issue && (gnt == i[0]))
                pend_vld_d[i] = 1'b0;
            else if (accept[i])
                pend_vld_d[i] = 1'b1;
        end
        if (s_HREADY) begin
            dph_vld_d = issue;
            dph_idx_d = gnt;
            if (issue) begin
                lock_vld_d = sel.lock;
                lock_idx_d = gnt;
            end else if (lock_vld_q && (trans[lock_idx_q] == 2'b00)) begin
                lock_vld_d = 1'b0;
            end
        end
        if (contended)
            last_d = gnt;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_vld_q <= 2'b00;
            dph_vld_q  <= 1'b0;
            dph_idx_q  <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            pend_vld_q <= pend_vld_d;
            dph_vld_q  <= dph_vld_d;
            dph_idx_q  <= dph_idx_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            last_q     <= last_d;
        end
    end

    // Payload is only ever observed through a valid slot, so it needs no reset.
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (accept[i] && !(issue && (gnt == i[0])))
                pend_q[i] <= live[i];
        end
    end

    always_comb begin
        s_HTRANS    = issue ? 2'b10 : 2'b00;
        s_HBURST    = 3'b000;
        s_HADDR     = issue ? sel.addr  : 32'h0;
        s_HSIZE     = issue ? sel.size  : 3'b000;
        s_HPROT     = issue ? sel.prot  : 4'b0000;
        s_HWRITE    = issue & sel.write;
        s_HMASTLOCK = issue & sel.lock;
        s_HWDATA    = !dph_vld_q ? 32'h0 : (dph_idx_q ? m1_HWDATA : m0_HWDATA);
    end

    assign m0_HREADY = mready[0];
    assign m1_HREADY = mready[1];
    assign m0_HRDATA = (dph_vld_q && !dph_idx_q) ? s_HRDATA : 32'h0;
    assign m1_HRDATA = (dph_vld_q &&  dph_idx_q) ? s_HRDATA : 32'h0;
    assign m0_HRESP  = dph_vld_q & ~dph_idx_q & s_HRESP;
    assign m1_HRESP  = dph_vld_q &  dph_idx_q & s_HRESP;

endmodule

// File: tb/tb_mfp_ahb_lite_arbiter_2m.sv
// Directed bench: instance a is fixed priority, instance b is round-robin; both share stimulus.
module tb_mfp_ahb_lite_arbiter_2m;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;

    logic [31:0] m0_HADDR, m1_HADDR, m0_HWDATA, m1_HWDATA;
    logic [ 2:0] m0_HBURST, m1_HBURST, m0_HSIZE, m1_HSIZE;
    logic        m0_HMASTLOCK, m1_HMASTLOCK, m0_HWRITE, m1_HWRITE;
    logic [ 3:0] m0_HPROT, m1_HPROT;
    logic [ 1:0] m0_HTRANS, m1_HTRANS;
    logic [31:0] s_HRDATA;
    logic        s_HREADY, s_HRESP;

    logic [31:0] a_m0_HRDATA, a_m1_HRDATA, b_m0_HRDATA, b_m1_HRDATA;
    logic        a_m0_HREADY, a_m1_HREADY, b_m0_HREADY, b_m1_HREADY;
    logic        a_m0_HRESP, a_m1_HRESP, b_m0_HRESP, b_m1_HRESP;
    logic [31:0] a_s_HADDR, b_s_HADDR, a_s_HWDATA, b_s_HWDATA;
    logic [ 2:0] a_s_HBURST, b_s_HBURST, a_s_HSIZE, b_s_HSIZE;
    logic        a_s_HMASTLOCK, b_s_HMASTLOCK, a_s_HWRITE, b_s_HWRITE;
    logic [ 3:0] a_s_HPROT, b_s_HPROT;
    logic [ 1:0] a_s_HTRANS, b_s_HTRANS;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    mfp_ahb_lite_arbiter_2m #(.ROUND_ROBIN(0)) u_a (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_HADDR(m0_HADDR), .m0_HBURST(m0_HBURST), .m0_HMASTLOCK(m0_HMASTLOCK),
        .m0_HPROT(m0_HPROT), .m0_HSIZE(m0_HSIZE), .m0_HTRANS(m0_HTRANS),
        .m0_HWRITE(m0_HWRITE), .m0_HWDATA(m0_HWDATA), .m0_HRDATA(a_m0_HRDATA),
        .m0_HREADY(a_m0_HREADY), .m0_HRESP(a_m0_HRESP),
        .m1_HADDR(m1_HADDR), .m1_HBURST(m1_HBURST), .m1_HMASTLOCK(m1_HMASTLOCK),
        .m1_HPROT(m1_HPROT), .m1_HSIZE(m1_HSIZE), .m1_HTRANS(m1_HTRANS),
        .m1_HWRITE(m1_HWRITE), .m1_HWDATA(m1_HWDATA), .m1_HRDATA(a_m1_HRDATA),
        .m1_HREADY(a_m1_HREADY), .m1_HRESP(a_m1_HRESP),
        .s_HADDR(a_s_HADDR), .s_HBURST(a_s_HBURST), .s_HMASTLOCK(a_s_HMASTLOCK),
        .s_HPROT(a_s_HPROT), .s_HSIZE(a_s_HSIZE), .s_HTRANS(a_s_HTRANS),
        .s_HWRITE(a_s_HWRITE), .s_HWDATA(a_s_HWDATA),
        .s_HRDATA(s_HRDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP)
    );

    mfp_ahb_lite_arbiter_2m #(.ROUND_ROBIN(1)) u_b (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_HADDR(m0_HADDR), .m0_HBURST(m0_HBURST), .m0_HMASTLOCK(m0_HMASTLOCK),
        .m0_HPROT(m0_HPROT), .m0_HSIZE(m0_HSIZE), .m0_HTRANS(m0_HTRANS),
        .m0_HWRITE(m0_HWRITE), .m0_HWDATA(m0_HWDATA), .m0_HRDATA(b_m0_HRDATA),
        .m0_HREADY(b_m0_HREADY), .m0_HRESP(b_m0_HRESP),
        .m1_HADDR(m1_HADDR), .m1_HBURST(m1_HBURST), .m1_HMASTLOCK(m1_HMASTLOCK),
        .m1_HPROT(m1_HPROT), .m1_HSIZE(m1_HSIZE), .m1_HTRANS(m1_HTRANS),
        .m1_HWRITE(m1_HWRITE), .m1_HWDATA(m1_HWDATA), .m1_HRDATA(b_m1_HRDATA),
        .m1_HREADY(b_m1_HREADY), .m1_HRESP(b_m1_HRESP),
        .s_HADDR(b_s_HADDR), .s_HBURST(b_s_HBURST), .s_HMASTLOCK(b_s_HMASTLOCK),
        .s_HPROT(b_s_HPROT), .s_HSIZE(b_s_HSIZE), .s_HTRANS(b_s_HTRANS),
        .s_HWRITE(b_s_HWRITE), .s_HWDATA(b_s_HWDATA),
        .s_HRDATA(s_HRDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_masters();
        m0_HTRANS = 2'b00; m0_HADDR = 32'h0; m0_HBURST = 3'b000; m0_HMASTLOCK = 1'b0;
        m0_HPROT = 4'h3; m0_HSIZE = 3'b010; m0_HWRITE = 1'b0; m0_HWDATA = 32'h0;
        m1_HTRANS = 2'b00; m1_HADDR = 32'h0; m1_HBURST = 3'b000; m1_HMASTLOCK = 1'b0;
        m1_HPROT = 4'h3; m1_HSIZE = 3'b010; m1_HWRITE = 1'b0; m1_HWDATA = 32'h0;
    endtask

    task automatic do_reset();
        idle_masters();
        s_HREADY = 1'b1; s_HRESP = 1'b0; s_HRDATA = 32'h0;
        HRESETn = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
    endtask

    initial begin
        logic [31:0] win_a, lose_a;

        // ---------------- single master write + read-back ----------------
        do_reset();
        #1;
        chk("rst_m0_ready", a_m0_HREADY, 1);
        chk("rst_m1_ready", a_m1_HREADY, 1);
        chk("rst_s_trans", a_s_HTRANS, 2'b00);
        chk("rst_s_addr", a_s_HADDR, 0);
        chk("rst_s_wdata", a_s_HWDATA, 0);
        chk("rst_m0_rdata", a_m0_HRDATA, 0);
        tick();

        m0_HTRANS = 2'b10; m0_HADDR = 32'h100; m0_HWRITE = 1'b1;
        #1;
        chk("single_trans", a_s_HTRANS, 2'b10);
        chk("single_addr", a_s_HADDR, 32'h100);
        chk("single_write", a_s_HWRITE, 1);
        chk("single_m0_ready", a_m0_HREADY, 1);
        tick();

        m0_HWDATA = 32'hDEADBEEF; m0_HWRITE = 1'b0;
        #1;
        chk("single_wdata", a_s_HWDATA, 32'hDEADBEEF);
        chk("single_rd_addr", a_s_HADDR, 32'h100);
        chk("single_rd_write", a_s_HWRITE, 0);
        chk("single_m0_ready2", a_m0_HREADY, 1);
        tick();

        m0_HTRANS = 2'b00; m0_HWDATA = 32'h0; s_HRDATA = 32'hDEADBEEF;
        #1;
        chk("single_rdata", a_m0_HRDATA, 32'hDEADBEEF);
        chk("single_m1_rdata0", a_m1_HRDATA, 0);
        chk("single_idle", a_s_HTRANS, 2'b00);
        tick();

        // ---------------- same-cycle collision, fixed priority ----------------
        do_reset();
        m0_HTRANS = 2'b10; m0_HADDR = 32'h10; m0_HWRITE = 1'b0;
        m1_HTRANS = 2'b10; m1_HADDR = 32'h20; m1_HWRITE = 1'b1;
        #1;
        chk("coll_first_addr", a_s_HADDR, 32'h20);
        chk("coll_first_write", a_s_HWRITE, 1);
        chk("coll_m0_ready_c1", a_m0_HREADY, 1);
        tick();

        m0_HTRANS = 2'b00; m0_HADDR = 32'h0;
        m1_HTRANS = 2'b00; m1_HADDR = 32'h0; m1_HWDATA = 32'h11112222;
        #1;
        chk("coll_m0_stall", a_m0_HREADY, 0);
        chk("coll_replay_addr", a_s_HADDR, 32'h10);
        chk("coll_replay_trans", a_s_HTRANS, 2'b10);
        chk("coll_replay_write", a_s_HWRITE, 0);
        chk("coll_m1_wdata", a_s_HWDATA, 32'h11112222);
        chk("coll_m1_ready", a_m1_HREADY, 1);
        tick();

        m1_HWDATA = 32'h0; s_HRDATA = 32'hCAFE0010;
        #1;
        chk("coll_m0_rdata", a_m0_HRDATA, 32'hCAFE0010);
        chk("coll_m0_ready_c3", a_m0_HREADY, 1);
        chk("coll_m1_rdata0", a_m1_HRDATA, 0);
        chk("coll_idle", a_s_HTRANS, 2'b00);
        tick();

        // ---------------- round-robin collisions (instance b) ----------------
        do_reset();
        for (int k = 0; k < 4; k++) begin
            win_a  = (k % 2 == 0) ? 32'h100 + 4 * k : 32'h200 + 4 * k;
            lose_a = (k % 2 == 0) ? 32'h200 + 4 * k : 32'h100 + 4 * k;
            m0_HTRANS = 2'b10; m0_HADDR = 32'h100 + 4 * k;
            m1_HTRANS = 2'b10; m1_HADDR = 32'h200 + 4 * k;
            #1;
            chk($sformatf("rr_win%0d", k), b_s_HADDR, win_a);
            tick();
            idle_masters();
            #1;
            chk($sformatf("rr_lose%0d", k), b_s_HADDR, lose_a);
            chk($sformatf("rr_lose_trans%0d", k), b_s_HTRANS, 2'b10);
            tick();
            #1;
            chk($sformatf("rr_idle%0d", k), b_s_HTRANS, 2'b00);
            tick();
        end

        // ---------------- INCR4 burst with 2 wait states per beat ----------------
        do_reset();
        m0_HTRANS = 2'b10; m0_HADDR = 32'h40; m0_HBURST = 3'b011; m0_HWRITE = 1'b1;
        #1;
        chk("burst_addr0", a_s_HADDR, 32'h40);
        chk("burst_single", a_s_HBURST, 3'b000);
        chk("burst_trans0", a_s_HTRANS, 2'b10);
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 3; w++) begin
                m0_HWDATA = 32'hB0000000 + k;
                if (k < 3) begin
                    m0_HTRANS = 2'b11; m0_HADDR = 32'h44 + 4 * k;
                end else begin
                    m0_HTRANS = 2'b00; m0_HADDR = 32'h0;
                end
                s_HREADY = (w == 2);
                #1;
                chk($sformatf("burst_ready_b%0d_w%0d", k, w), a_m0_HREADY, (w == 2));
                chk($sformatf("burst_wdata_b%0d_w%0d", k, w), a_s_HWDATA, 32'hB0000000 + k);
                if (w == 2 && k < 3) begin
                    chk($sformatf("burst_trans_b%0d", k + 1), a_s_HTRANS, 2'b10);
                    chk($sformatf("burst_addr_b%0d", k + 1), a_s_HADDR, 32'h44 + 4 * k);
                end else begin
                    chk($sformatf("burst_noissue_b%0d_w%0d", k, w), a_s_HTRANS, 2'b00);
                end
                tick();
            end
        end
        idle_masters();
        s_HREADY = 1'b1;
        tick();

        // ---------------- lock (instance b, where round-robin would favour m0) ----------------
        do_reset();
        m1_HTRANS = 2'b10; m1_HADDR = 32'h300; m1_HMASTLOCK = 1'b1; m1_HWRITE = 1'b1;
        #1;
        chk("lock_addr0", b_s_HADDR, 32'h300);
        chk("lock_bit0", b_s_HMASTLOCK, 1);
        tick();
        m1_HADDR = 32'h304;
        m0_HTRANS = 2'b10; m0_HADDR = 32'h10;
        #1;
        chk("lock_addr1", b_s_HADDR, 32'h304);
        chk("lock_m0_ready1", b_m0_HREADY, 1);
        tick();
        m1_HADDR = 32'h308; m1_HMASTLOCK = 1'b0;
        m0_HTRANS = 2'b00; m0_HADDR = 32'h0;
        #1;
        chk("lock_unlock_addr", b_s_HADDR, 32'h308);
        chk("lock_unlock_bit", b_s_HMASTLOCK, 0);
        chk("lock_m0_stall", b_m0_HREADY, 0);
        tick();
        idle_masters();
        #1;
        chk("lock_m0_issue", b_s_HADDR, 32'h10);
        chk("lock_m0_trans", b_s_HTRANS, 2'b10);
        tick();
        #1;
        chk("lock_m0_ready_end", b_m0_HREADY, 1);
        chk("lock_idle_end", b_s_HTRANS, 2'b00);
        tick();

        // ---------------- async reset mid-replay, then ERROR response ----------------
        do_reset();
        m0_HTRANS = 2'b10; m0_HADDR = 32'h10;
        m1_HTRANS = 2'b10; m1_HADDR = 32'h20;
        #1;
        tick();
        idle_masters();
        s_HRDATA = 32'h5A5A5A5A;
        #1;
        chk("rr_pre_m0_stall", a_m0_HREADY, 0);
        HRESETn = 1'b0;
        #1;
        chk("arst_m0_ready", a_m0_HREADY, 1);
        chk("arst_m1_ready", a_m1_HREADY, 1);
        chk("arst_s_trans", a_s_HTRANS, 2'b00);
        chk("arst_s_addr", a_s_HADDR, 0);
        chk("arst_m1_rdata", a_m1_HRDATA, 0);
        chk("arst_s_wdata", a_s_HWDATA, 0);
        tick();
        tick();
        HRESETn = 1'b1;
        s_HRDATA = 32'h0;
        m1_HTRANS = 2'b10; m1_HADDR = 32'h50;
        #1;
        chk("err_issue", a_s_HADDR, 32'h50);
        tick();
        m1_HTRANS = 2'b00; m1_HADDR = 32'h0;
        s_HREADY = 1'b0; s_HRESP = 1'b1;
        #1;
        chk("err_resp1", a_m1_HRESP, 1);
        chk("err_ready1", a_m1_HREADY, 0);
        chk("err_m0_resp", a_m0_HRESP, 0);
        tick();
        s_HREADY = 1'b1;
        #1;
        chk("err_resp2", a_m1_HRESP, 1);
        chk("err_ready2", a_m1_HREADY, 1);
        tick();
        s_HRESP = 1'b0;
        #1;
        chk("err_resp_done", a_m1_HRESP, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
